// File: rtl/tiny_platform_dmem_pkg.sv
// Shared data-memory bus types for the tiny platform.
package tiny_platform_dmem_pkg;

  localparam int unsigned DmemAddrW = 32;
  localparam int unsigned DmemDataW = 32;
  localparam int unsigned DmemBeW   = 4;

  typedef struct packed {
    logic                 we;
    logic [DmemAddrW-1:0] addr;
    logic [DmemBeW-1:0]   be;
    logic [DmemDataW-1:0] wdata;
  } dmem_req_t;

  typedef struct packed {
    logic [DmemDataW-1:0] rdata;
    logic                 err;
  } dmem_rsp_t;

endpackage

// File: rtl/tiny_platform_id_fifo.sv
// Small in-order FIFO of host IDs for issued-but-unanswered transactions.
module tiny_platform_id_fifo #(
  parameter int unsigned Depth = 2,
  parameter int unsigned Width = 1,
  parameter int unsigned CntW  = $clog2(Depth + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push,
  input  logic [Width-1:0] push_data,
  input  logic             pop,
  output logic [Width-1:0] head,
  output logic [CntW-1:0]  count,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

  logic [Width-1:0] mem [Depth];
  logic [PtrW-1:0]  wptr;
  logic [PtrW-1:0]  rptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CntW'(Depth));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rptr];

  // Pointers wrap modulo Depth so non-power-of-two depths work.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= (wptr == PtrW'(Depth - 1)) ? '0 : wptr + PtrW'(1);
      if (do_pop)  rptr <= (rptr == PtrW'(Depth - 1)) ? '0 : rptr + PtrW'(1);
      if (do_push && !do_pop)      count <= count + CntW'(1);
      else if (do_pop && !do_push) count <= count - CntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wptr] <= push_data;
  end

endmodule

// File: rtl/tiny_platform_dmem_arbiter.sv
// Round-robin arbiter sharing one dmem port between hosts, with request locking
// and in-order response routing by tracked host ID.
module tiny_platform_dmem_arbiter
  import tiny_platform_dmem_pkg::*;
#(
  parameter int unsigned NumHosts       = 2,
  parameter int unsigned MaxOutstanding = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [NumHosts-1:0]     host_req_i,
  output logic [NumHosts-1:0]     host_gnt_o,
  input  logic [NumHosts-1:0]     host_we_i,
  input  logic [NumHosts*32-1:0]  host_addr_i,
  input  logic [NumHosts*4-1:0]   host_be_i,
  input  logic [NumHosts*32-1:0]  host_wdata_i,
  output logic [NumHosts-1:0]     host_rvalid_o,
  output logic [31:0]             host_rdata_o,
  output logic                    host_err_o,
  output logic                    dev_req_o,
  input  logic                    dev_gnt_i,
  output logic                    dev_we_o,
  output logic [31:0]             dev_addr_o,
  output logic [3:0]              dev_be_o,
  output logic [31:0]             dev_wdata_o,
  input  logic                    dev_rvalid_i,
  input  logic [31:0]             dev_rdata_i,
  input  logic                    dev_err_i,
  output logic                    unexpected_rsp_o
);

  localparam int unsigned IdW  = $clog2(NumHosts);
  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

  logic [IdW-1:0]  rr_ptr;
  logic            lock;
  logic [IdW-1:0]  lock_id;
  logic [IdW-1:0]  sel;
  logic [IdW-1:0]  rr_next;
  logic            found;
  logic            grant;
  logic            rsp_pop;
  logic [IdW-1:0]  id_head;
  logic [CntW-1:0] id_count;
  logic            id_full;
  logic            id_empty;
  dmem_req_t       host_pl [NumHosts];
  dmem_req_t       sel_pl;
  dmem_rsp_t       rsp;

  always_comb begin
    for (int unsigned h = 0; h < NumHosts; h++) begin
      host_pl[h] = '{we:    host_we_i[h],
                     addr:  host_addr_i[h*DmemAddrW +: DmemAddrW],
                     be:    host_be_i[h*DmemBeW +: DmemBeW],
                     wdata: host_wdata_i[h*DmemDataW +: DmemDataW]};
    end
  end

  // A stalled (locked) host keeps the port; otherwise search from rr_ptr with wrap.
  always_comb begin
    sel   = rr_ptr;
    found = 1'b0;
    if (lock) begin
      sel = lock_id;
    end else begin
      for (int unsigned i = 0; i < NumHosts; i++) begin
        if (!found && host_req_i[IdW'((32'(rr_ptr) + i) % NumHosts)]) begin
          sel   = IdW'((32'(rr_ptr) + i) % NumHosts);
          found = 1'b1;
        end
      end
    end
  end

  assign rr_next = IdW'((32'(sel) + 32'd1) % NumHosts);

  // Issue is gated on registered fullness only, so rvalid never reaches dev_req_o.
  assign dev_req_o = rst_ni & host_req_i[sel] & ~id_full;
  assign grant     = dev_req_o & dev_gnt_i;
  assign sel_pl    = host_pl[sel];
  assign dev_we_o    = sel_pl.we;
  assign dev_addr_o  = sel_pl.addr;
  assign dev_be_o    = sel_pl.be;
  assign dev_wdata_o = sel_pl.wdata;

  always_comb begin
    host_gnt_o = '0;
    if (grant) host_gnt_o[sel] = 1'b1;
  end

  assign rsp          = '{rdata: dev_rdata_i, err: dev_err_i};
  assign host_rdata_o = rsp.rdata;
  assign host_err_o   = rsp.err;
  assign rsp_pop      = rst_ni & dev_rvalid_i & ~id_empty;

  always_comb begin
    host_rvalid_o = '0;
    if (rsp_pop) host_rvalid_o[id_head] = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr           <= '0;
      lock             <= 1'b0;
      lock_id          <= '0;
      unexpected_rsp_o <= 1'b0;
    end else begin
      if (grant) begin
        rr_ptr <= rr_next;
        lock   <= 1'b0;
      end else if (dev_req_o) begin
        lock    <= 1'b1;
        lock_id <= sel;
      end else begin
        lock <= 1'b0;  // locked host withdrew its request
      end
      if (dev_rvalid_i && id_empty) unexpected_rsp_o <= 1'b1;
    end
  end

  tiny_platform_id_fifo #(
    .Depth (MaxOutstanding),
    .Width (IdW),
    .CntW  (CntW)
  ) u_id_fifo (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .push      (grant),
    .push_data (sel),
    .pop       (rsp_pop),
    .head      (id_head),
    .count     (id_count),
    .full      (id_full),
    .empty     (id_empty)
  );

  lock_held_a: assert property (@(posedge clk_i) disable iff (!rst_ni) lock |-> host_req_i[lock_id])
    else $error("locked host dropped its request before grant");

  count_bound_a: assert property (@(posedge clk_i) disable iff (!rst_ni) 32'(id_count) <= MaxOutstanding)
    else $error("outstanding count exceeded its bound");

endmodule
